pipeline_ctrl: RTL and testbench

- Sequencer for the 3-stage core (IF_ID -> EX_MEM -> WB).
- Drives sub-block resets, the program/data file strobes, the pipeline-register ENABLE/RESET pins and the PC enable.
- Handles the boot-load-run-drain-dump lifecycle.
- In RUN, inserts one bubble on load-use hazards and flushes the wrong-path instruction on a taken branch.

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_ctrl_hazard.sv | 27 ++
 rtl/pipeline_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and defaults for the 3-stage core sequencer.
// Covers FSM state codes, write-back source selects and the reset/drain lengths.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_LOAD   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DUMP   = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    localparam logic [1:0] MXRB_SEL_ALU = 2'b00;
    localparam logic [1:0] MXRB_SEL_DM  = 2'b01;
    localparam logic [1:0] MXRB_SEL_PC  = 2'b10;

    localparam int unsigned DEF_RST_CYCLES   = 32'd2;
    localparam int unsigned DEF_DRAIN_CYCLES = 32'd2;

    localparam int CNT_W = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use detector: flags an ID instruction that reads a register an in-flight
// data-memory load in EX is about to write. Purely combinational.
module hazard_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [1:0] MXRB_DM = MXRB_SEL_DM
) (
    input  logic [3:0] id_ra_i,
    input  logic [3:0] id_rb_i,
    input  logic       id_use_ra_i,
    input  logic       id_use_rb_i,
    input  logic [3:0] ex_wc_i,
    input  logic       ex_w_rb_i,
    input  logic [1:0] ex_s_mxrb_i,
    output logic       hazard_o
);

    logic ex_is_load_s;
    logic ra_match_s;
    logic rb_match_s;

    assign ex_is_load_s = ex_w_rb_i & (ex_s_mxrb_i == MXRB_DM);
    assign ra_match_s   = id_use_ra_i & (id_ra_i == ex_wc_i);
    assign rb_match_s   = id_use_rb_i & (id_rb_i == ex_wc_i);
    assign hazard_o     = ex_is_load_s & (ra_match_s | rb_match_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Lifecycle sequencer (boot, load, run, drain, dump) for the 3-stage core.
// Optional performance counters are built only when PIPELINE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter logic [1:0]  MXRB_DM      = MXRB_SEL_DM
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic        halt_req,
    input  logic        branch_taken,
    input  logic [3:0]  id_RA,
    input  logic [3:0]  id_RB,
    input  logic        id_use_RA,
    input  logic        id_use_RB,
    input  logic [3:0]  ex_WC,
    input  logic        ex_W_RB,
    input  logic [1:0]  ex_S_MXRB,
    output logic        pc_RESET,
    output logic        im_RESET,
    output logic        rb_RESET,
    output logic        tf_RESET,
    output logic        dm_RESET,
    output logic        pc_ENABLE,
    output logic        reg_ifid_exmem_ENABLE,
    output logic        reg_ifid_exmem_RESET,
    output logic        reg_exmem_wb_ENABLE,
    output logic        reg_exmem_wb_RESET,
    output logic        im_read_file,
    output logic        dm_write_file,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard_s;
    logic             in_run_s;
    logic             flush_s;
    logic             stall_s;
    logic             halt_s;

    hazard_unit #(
        .MXRB_DM (MXRB_DM)
    ) u_hazard (
        .id_ra_i     (id_RA),
        .id_rb_i     (id_RB),
        .id_use_ra_i (id_use_RA),
        .id_use_rb_i (id_use_RB),
        .ex_wc_i     (ex_WC),
        .ex_w_rb_i   (ex_W_RB),
        .ex_s_mxrb_i (ex_S_MXRB),
        .hazard_o    (hazard_s)
    );

    // A taken branch squashes the hazard and halt of the wrong-path ID instruction.
    assign in_run_s = (state_q == ST_RUN);
    assign flush_s  = in_run_s & branch_taken;
    assign stall_s  = in_run_s & ~branch_taken & hazard_s;
    assign halt_s   = in_run_s & ~branch_taken & ~hazard_s & halt_req;

    // Lifecycle FSM with a shared down-counter for the RST and DRAIN dwell times.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RST;
            cnt_q   <= RST_LOAD;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_q == '0) state_q <= ST_LOAD;
                    else             cnt_q   <= cnt_q - CNT_ONE;
                end
                ST_LOAD: state_q <= ST_IDLE;
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                    else       state_q <= ST_IDLE;
                end
                ST_RUN: begin
                    if (halt_s) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= DRAIN_LOAD;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) state_q <= ST_DUMP;
                    else             cnt_q   <= cnt_q - CNT_ONE;
                end
                ST_DUMP: state_q <= ST_HALTED;
                ST_HALTED: begin
                    if (start) begin
                        state_q <= ST_RST;
                        cnt_q   <= RST_LOAD;
                    end else begin
                        state_q <= ST_HALTED;
                    end
                end
                default: begin
                    state_q <= ST_RST;
                    cnt_q   <= RST_LOAD;
                end
            endcase
        end
    end

    // Control decode from the state register plus the RUN stall/flush/halt terms.
    always_comb begin
        pc_RESET              = 1'b0;
        im_RESET              = 1'b0;
        rb_RESET              = 1'b0;
        tf_RESET              = 1'b0;
        dm_RESET              = 1'b0;
        pc_ENABLE             = 1'b0;
        reg_ifid_exmem_ENABLE = 1'b0;
        reg_ifid_exmem_RESET  = 1'b0;
        reg_exmem_wb_ENABLE   = 1'b0;
        reg_exmem_wb_RESET    = 1'b0;
        im_read_file          = 1'b0;
        dm_write_file         = 1'b0;
        case (state_q)
            ST_LOAD:   im_read_file = 1'b1;
            ST_IDLE:   im_read_file = 1'b0;
            ST_RUN: begin
                pc_ENABLE             = ~(stall_s | halt_s);
                reg_ifid_exmem_ENABLE = 1'b1;
                reg_ifid_exmem_RESET  = flush_s | stall_s | halt_s;
                reg_exmem_wb_ENABLE   = 1'b1;
            end
            ST_DRAIN: begin
                reg_ifid_exmem_RESET = 1'b1;
                reg_exmem_wb_ENABLE  = 1'b1;
            end
            ST_DUMP:   dm_write_file = 1'b1;
            ST_HALTED: dm_write_file = 1'b0;
            default: begin
                pc_RESET             = 1'b1;
                im_RESET             = 1'b1;
                rb_RESET             = 1'b1;
                tf_RESET             = 1'b1;
                dm_RESET             = 1'b1;
                reg_ifid_exmem_RESET = 1'b1;
                reg_exmem_wb_RESET   = 1'b1;
            end
        endcase
    end

    assign state = state_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating performance counters, cleared whenever the sequencer is in RST.
    always_ff @(posedge CLK) begin
        if (RESET || (state_q == ST_RST)) begin
            cycle_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (in_run_s || (state_q == ST_DRAIN)) cycle_cnt_q <= sat_inc(cycle_cnt_q);
            if (stall_s)                           stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush_s)                           flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign cycle_cnt = 32'd0;
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a lifecycle model checked every cycle plus
// hand-computed spot checks of boot, load-use, branch, halt and reset-in-drain.
module tb_pipeline_ctrl;

    localparam int RST_CYC   = 2;
    localparam int DRAIN_CYC = 2;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET, start, halt_req, branch_taken;
    logic [3:0]  id_RA, id_RB, ex_WC;
    logic        id_use_RA, id_use_RB, ex_W_RB;
    logic [1:0]  ex_S_MXRB;
    logic        pc_RESET, im_RESET, rb_RESET, tf_RESET, dm_RESET, pc_ENABLE;
    logic        reg_ifid_exmem_ENABLE, reg_ifid_exmem_RESET;
    logic        reg_exmem_wb_ENABLE, reg_exmem_wb_RESET;
    logic        im_read_file, dm_write_file;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    int im_pulses = 0;
    int dm_pulses = 0;

    pipeline_ctrl #(
        .RST_CYCLES   (RST_CYC),
        .DRAIN_CYCLES (DRAIN_CYC),
        .MXRB_DM      (2'b01)
    ) dut (
        .CLK (CLK), .RESET (RESET), .start (start), .halt_req (halt_req),
        .branch_taken (branch_taken), .id_RA (id_RA), .id_RB (id_RB),
        .id_use_RA (id_use_RA), .id_use_RB (id_use_RB), .ex_WC (ex_WC),
        .ex_W_RB (ex_W_RB), .ex_S_MXRB (ex_S_MXRB),
        .pc_RESET (pc_RESET), .im_RESET (im_RESET), .rb_RESET (rb_RESET),
        .tf_RESET (tf_RESET), .dm_RESET (dm_RESET), .pc_ENABLE (pc_ENABLE),
        .reg_ifid_exmem_ENABLE (reg_ifid_exmem_ENABLE),
        .reg_ifid_exmem_RESET (reg_ifid_exmem_RESET),
        .reg_exmem_wb_ENABLE (reg_exmem_wb_ENABLE),
        .reg_exmem_wb_RESET (reg_exmem_wb_RESET),
        .im_read_file (im_read_file), .dm_write_file (dm_write_file),
        .state (state), .cycle_cnt (cycle_cnt), .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hz_now();
        return ex_W_RB && (ex_S_MXRB == 2'b01) &&
               ((id_use_RA && (id_RA == ex_WC)) || (id_use_RB && (id_RB == ex_WC)));
    endfunction

    // Control vector order: 5 sub-block resets, pc_EN, ifid_EN, ifid_RST, exwb_EN, exwb_RST, im_read, dm_write
    function automatic logic [11:0] exp_ctrl(input int st, input bit br, input bit hzd, input bit hlt);
        case (st)
            0: return 12'b11111_0_0_1_0_1_0_0;
            1: return 12'b00000_0_0_0_0_0_1_0;
            3: begin
                if (br)              return 12'b00000_1_1_1_1_0_0_0;
                else if (hzd || hlt) return 12'b00000_0_1_1_1_0_0_0;
                else                 return 12'b00000_1_1_0_1_0_0_0;
            end
            4: return 12'b00000_0_0_1_1_0_0_0;
            5: return 12'b00000_0_0_0_0_0_0_1;
            default: return 12'b00000_0_0_0_0_0_0_0;
        endcase
    endfunction

    logic [11:0] dut_ctrl;
    assign dut_ctrl = {pc_RESET, im_RESET, rb_RESET, tf_RESET, dm_RESET, pc_ENABLE,
                       reg_ifid_exmem_ENABLE, reg_ifid_exmem_RESET,
                       reg_exmem_wb_ENABLE, reg_exmem_wb_RESET, im_read_file, dm_write_file};

    int          m_state = 0;
    int          m_age   = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_cyc = 32'd0, m_stl = 32'd0, m_fl = 32'd0;

    // Lifecycle model: state plus time spent in it, counters as plain tallies.
    always @(posedge CLK) begin
        if (RESET) begin
            m_state <= 0;
            m_age   <= 0;
            m_valid <= 1'b1;
        end else begin
            case (m_state)
                0: if (m_age >= RST_CYC - 1) begin m_state <= 1; m_age <= 0; end
                   else m_age <= m_age + 1;
                1: m_state <= 2;
                2: if (start) m_state <= 3;
                3: if (!branch_taken && !hz_now() && halt_req) begin m_state <= 4; m_age <= 0; end
                4: if (m_age >= DRAIN_CYC - 1) m_state <= 5;
                   else m_age <= m_age + 1;
                5: m_state <= 6;
                6: if (start) begin m_state <= 0; m_age <= 0; end
                default: m_state <= 0;
            endcase
        end
        if (RESET || m_state == 0) begin
            m_cyc <= 32'd0; m_stl <= 32'd0; m_fl <= 32'd0;
        end else if (PERF) begin
            if (m_state == 3 || m_state == 4)           m_cyc <= m_cyc + 32'd1;
            if (m_state == 3 && branch_taken)            m_fl  <= m_fl + 32'd1;
            if (m_state == 3 && !branch_taken && hz_now()) m_stl <= m_stl + 32'd1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle away from the clock edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("ctrl", {20'd0, dut_ctrl},
                {20'd0, exp_ctrl(m_state, branch_taken, hz_now(), halt_req)});
            chk("state", {29'd0, state}, m_state);
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("stall_cnt", stall_cnt, m_stl);
            chk("flush_cnt", flush_cnt, m_fl);
            if (im_read_file === 1'b1)  im_pulses++;
            if (dm_write_file === 1'b1) dm_pulses++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        start = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
        id_RA = 4'd0; id_RB = 4'd0; id_use_RA = 1'b0; id_use_RB = 1'b0;
        ex_WC = 4'd0; ex_W_RB = 1'b0; ex_S_MXRB = 2'b00;
    endtask

    initial begin
        RESET = 1'b1;
        clear_in();
        tick();
        RESET = 1'b0;
        #1 chk("boot c1 pc_RESET", pc_RESET, 32'd1); chk("boot c1 state", state, 32'd0);
        tick();
        #1 chk("boot c2 rb_RESET", rb_RESET, 32'd1); chk("boot c2 im_read", im_read_file, 32'd0);
        tick();
        #1 chk("boot c3 im_read", im_read_file, 32'd1); chk("boot c3 dm_RESET", dm_RESET, 32'd0);
        tick();
        #1 chk("boot c4 state", state, 32'd2); chk("boot c4 im_read", im_read_file, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1 chk("run state", state, 32'd3); chk("run pc_EN", pc_ENABLE, 32'd1);
        chk("run ifid_EN", reg_ifid_exmem_ENABLE, 32'd1); chk("run exwb_EN", reg_exmem_wb_ENABLE, 32'd1);

        ex_W_RB = 1'b1; ex_S_MXRB = 2'b01; ex_WC = 4'd5; id_RA = 4'd5; id_use_RA = 1'b1;
        #1 chk("lu pc_EN", pc_ENABLE, 32'd0); chk("lu ifid_RST", reg_ifid_exmem_RESET, 32'd1);
        chk("lu exwb_EN", reg_exmem_wb_ENABLE, 32'd1);
        tick();
        ex_W_RB = 1'b0;
        #1 chk("bubble pc_EN", pc_ENABLE, 32'd1); chk("bubble ifid_RST", reg_ifid_exmem_RESET, 32'd0);
        chk("lu stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
        ex_W_RB = 1'b1; ex_S_MXRB = 2'b00;
        #1 chk("alu src no stall", pc_ENABLE, 32'd1);
        tick();

        ex_S_MXRB = 2'b01; ex_WC = 4'd7; id_RB = 4'd7; id_use_RB = 1'b1;
        #1 chk("lu RB pc_EN", pc_ENABLE, 32'd0);
        id_use_RB = 1'b0;
        #1 chk("RB unused pc_EN", pc_ENABLE, 32'd1);
        tick();

        ex_WC = 4'd5; id_use_RA = 1'b1; halt_req = 1'b1; branch_taken = 1'b1;
        #1 chk("br ifid_RST", reg_ifid_exmem_RESET, 32'd1); chk("br pc_EN", pc_ENABLE, 32'd1);
        tick();
        clear_in();
        #1 chk("br state", state, 32'd3); chk("br flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
        chk("br stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1 chk("start ignored in RUN", state, 32'd3);

        halt_req = 1'b1;
        #1 chk("halt pc_EN", pc_ENABLE, 32'd0);
        tick();
        halt_req = 1'b0;
        #1 chk("drain1 state", state, 32'd4); chk("drain1 pc_EN", pc_ENABLE, 32'd0);
        tick();
        #1 chk("drain2 state", state, 32'd4); chk("drain2 pc_EN", pc_ENABLE, 32'd0);
        tick();
        #1 chk("dump state", state, 32'd5); chk("dump strobe", dm_write_file, 32'd1);
        tick();
        #1 chk("halted state", state, 32'd6); chk("halted strobe", dm_write_file, 32'd0);
        chk("halted cycle_cnt", cycle_cnt, PERF ? 32'd8 : 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1 chk("restart state", state, 32'd0);
        repeat (3) tick();
        #1 chk("reload idle", state, 32'd2);

        start = 1'b1;
        tick();
        start = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #1 chk("drain again", state, 32'd4);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1 chk("mid-drain reset state", state, 32'd0);
        chk("mid-drain cycle_cnt", cycle_cnt, 32'd0);
        chk("mid-drain stall_cnt", stall_cnt, 32'd0);
        chk("mid-drain flush_cnt", flush_cnt, 32'd0);
        repeat (3) tick();
        #1 chk("post-reset idle", state, 32'd2);
        tick();
        chk("dm_write pulses", dm_pulses, 32'd1);
        chk("im_read pulses", im_pulses, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
